// File: rtl/mem_port1_arbiter.sv
// Two-requester arbiter for RAM port 1: byte/half/word loads with extension, word stores,
// and read-modify-write byte/half stores. Define MEM_ARB_FIXED_PRIO_EN for fixed req0 priority.

module mem_port1_lane (
  input  logic       sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module mem_port1_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_write_1,
  output logic        mem_read_1,
  output logic [31:0] mem_address_1,
  output logic [31:0] mem_write_data_1,
  input  logic [31:0] mem_read_data_1
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t          state;
  logic            rr_ptr;
  req_t            cur;
  logic            cur_id;
  logic            cur_err;
  req_t [1:0]      req;
  req_t            win_req;
  logic [1:0]      valid;
  logic [1:0]      grant;
  logic            accept;
  logic            win;
  logic            bad;

  assign req[0]  = {req0_we, req0_size, req0_unsigned, req0_addr, req0_wdata};
  assign req[1]  = {req1_we, req1_size, req1_unsigned, req1_addr, req1_wdata};
  assign valid   = {req1_valid, req0_valid};

  always_comb begin
    grant = 2'b00;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
`else
    if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
    else                grant = valid;
`endif
  end

  assign accept     = rst_n && (state == IDLE) && (|grant);
  assign win        = grant[1];
  assign win_req    = win ? req[1] : req[0];
  assign req0_ready = accept & grant[0];
  assign req1_ready = accept & grant[1];

  // Errors are resolved at accept so the bad request never touches the RAM.
  assign bad = (win_req.size == 2'b11) ||
               (win_req.size == 2'b01 && win_req.addr[0]) ||
               (win_req.size == 2'b10 && win_req.addr[1:0] != 2'b00) ||
               (win_req.addr >= 32'(MEM_BYTES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      cur     <= '0;
      cur_id  <= 1'b0;
      cur_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cur     <= win_req;
          cur_id  <= win;
          cur_err <= bad;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_ptr  <= ~win;
`endif
          if (bad)                                      state <= RESP;
          else if (win_req.we && win_req.size == 2'b10) state <= WRITE;
          else                                          state <= READ;
        end
        READ:  state <= cur.we ? WRITE : RESP;
        WRITE: state <= RESP;
        RESP:  state <= IDLE;
      endcase
    end
  end

  // Store merge: unselected lanes keep the word read back in READ.
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [NUM_LANES-1:0][7:0] wr_lanes;
  assign rd_lanes = mem_read_data_1;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic       sel;
    logic [7:0] nb;
    always_comb begin
      sel = 1'b1;
      nb  = cur.wdata[8*k +: 8];
      case (cur.size)
        2'b00: begin
          sel = (cur.addr[1:0] == LANE);
          nb  = cur.wdata[7:0];
        end
        2'b01: begin
          sel = (cur.addr[1] == LANE[1]);
          nb  = cur.wdata[8*(k%2) +: 8];
        end
        default: ;
      endcase
    end
    mem_port1_lane u_lane (
      .sel      (sel),
      .old_byte (rd_lanes[k]),
      .new_byte (nb),
      .merged   (wr_lanes[k])
    );
  end

  assign mem_read_1       = rst_n && (state == READ);
  assign mem_write_1      = rst_n && (state == WRITE);
  assign mem_address_1    = {cur.addr[31:2], 2'b00};
  assign mem_write_data_1 = (state == WRITE) ? wr_lanes : 32'h0;

  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] rsp_data;
  logic        rsp_any;

  assign shifted = mem_read_data_1 >> {cur.addr[1:0], 3'b000};

  always_comb begin
    case (cur.size)
      2'b00:   load_data = {{24{~cur.uns & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~cur.uns & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign rsp_any    = rst_n && (state == RESP);
  assign rsp_data   = (cur.we || cur_err) ? 32'h0 : load_data;
  assign rsp0_valid = rsp_any && !cur_id;
  assign rsp1_valid = rsp_any &&  cur_id;
  assign rsp0_err   = rsp0_valid && cur_err;
  assign rsp1_err   = rsp1_valid && cur_err;
  assign rsp0_rdata = rsp0_valid ? rsp_data : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rsp_data : 32'h0;

endmodule
